// File: rtl/calc_serial_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : calc_serial_receiver
//  Function : Oversamples the calculator's serial result stream, deserializes
//             32-bit frames and queues them in a first-word-fall-through FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module calc_serial_receiver #(
  parameter int FRAME_W = 32,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 3
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               ClkTx,
  input  logic               DoutValid,
  input  logic               DataOut,
  input  logic               Pop,
  input  logic               ClearErr,
  output logic [FRAME_W-1:0] Frame,
  output logic [7:0]         OpA,
  output logic [7:0]         OpB,
  output logic [7:0]         AluOut,
  output logic [3:0]         AluSel,
  output logic [3:0]         AluFlags,
  output logic               Empty,
  output logic               Full,
  output logic [CNT_W-1:0]   Level,
  output logic               FrameErr,
  output logic               Overflow
);

  localparam int c_ADDR_W = $clog2(DEPTH);
  localparam int c_BCNT_W = $clog2(FRAME_W + 1);
  localparam logic [c_BCNT_W-1:0] c_FULL_CNT = c_BCNT_W'(FRAME_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic r_clkTxS1, r_clkTxS2, r_clkTxS3;
  logic r_validS1, r_validS2;
  logic r_dataS1, r_dataS2;
  logic w_sampleEdge;

  logic [FRAME_W-1:0]  r_shiftReg;
  logic [c_BCNT_W-1:0] r_bitCnt;
  logic                w_shiftEn;
  logic                w_cntClr;
  logic                w_errSet;
  logic                w_commit;

  logic [FRAME_W-1:0] r_mem [DEPTH];
  logic [c_ADDR_W:0]  r_wrPtr, r_rdPtr;
  logic               w_empty, w_full;
  logic               w_popAcc, w_push, w_ovfSet;
  logic               r_frameErr, r_overflow;

  // Data shares ClkTx's two-stage path so the sampled bit lines up with the edge
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_clkTxS1 <= 1'b0;
      r_clkTxS2 <= 1'b0;
      r_clkTxS3 <= 1'b0;
      r_validS1 <= 1'b0;
      r_validS2 <= 1'b0;
      r_dataS1  <= 1'b0;
      r_dataS2  <= 1'b0;
    end else begin
      r_clkTxS1 <= ClkTx;
      r_clkTxS2 <= r_clkTxS1;
      r_clkTxS3 <= r_clkTxS2;
      r_validS1 <= DoutValid;
      r_validS2 <= r_validS1;
      r_dataS1  <= DataOut;
      r_dataS2  <= r_dataS1;
    end
  end

  assign w_sampleEdge = r_clkTxS2 & ~r_clkTxS3;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_shiftEn   = 1'b0;
    w_cntClr    = 1'b0;
    w_errSet    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        w_cntClr = 1'b1;
        if (r_validS2) w_nextState = RECV;
      end
      RECV: begin
        if (!r_validS2) begin
          if (r_bitCnt == c_FULL_CNT) begin
            w_nextState = COMMIT;
          end else begin
            w_errSet    = 1'b1;
            w_nextState = IDLE;
          end
        end else if (w_sampleEdge) begin
          if (r_bitCnt < c_FULL_CNT) begin
            w_shiftEn = 1'b1;
          end else begin
            w_errSet    = 1'b1;
            w_nextState = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!r_validS2) w_nextState = IDLE;
      end
      COMMIT: begin
        w_commit    = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_shiftReg <= '0;
      r_bitCnt   <= '0;
    end else if (w_cntClr) begin
      r_shiftReg <= '0;
      r_bitCnt   <= '0;
    end else if (w_shiftEn) begin
      r_shiftReg <= {r_shiftReg[FRAME_W-2:0], r_dataS2};
      r_bitCnt   <= r_bitCnt + 1'b1;
    end
  end

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign w_empty  = (r_wrPtr == r_rdPtr);
  assign w_full   = (r_wrPtr[c_ADDR_W] != r_rdPtr[c_ADDR_W]) &&
                    (r_wrPtr[c_ADDR_W-1:0] == r_rdPtr[c_ADDR_W-1:0]);
  assign w_popAcc = Pop & ~w_empty;
  assign w_push   = w_commit & (~w_full | w_popAcc);
  assign w_ovfSet = w_commit & w_full & ~w_popAcc;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push)   r_wrPtr <= r_wrPtr + 1'b1;
      if (w_popAcc) r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (w_push) r_mem[r_wrPtr[c_ADDR_W-1:0]] <= r_shiftReg;
  end

  // A set event in the same cycle as ClearErr keeps the flag asserted
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_frameErr <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_errSet)      r_frameErr <= 1'b1;
      else if (ClearErr) r_frameErr <= 1'b0;
      if (w_ovfSet)      r_overflow <= 1'b1;
      else if (ClearErr) r_overflow <= 1'b0;
    end
  end

  assign Frame    = w_empty ? '0 : r_mem[r_rdPtr[c_ADDR_W-1:0]];
  assign OpA      = Frame[31:24];
  assign OpB      = Frame[23:16];
  assign AluOut   = Frame[15:8];
  assign AluSel   = Frame[7:4];
  assign AluFlags = Frame[3:0];
  assign Empty    = w_empty;
  assign Full     = w_full;
  assign Level    = CNT_W'(r_wrPtr - r_rdPtr);
  assign FrameErr = r_frameErr;
  assign Overflow = r_overflow;

endmodule
`default_nettype wire

// File: doc/calc_serial_receiver.md
Name: calc_serial_receiver

Overview:
- Downstream consumer of the binary calculator's serial output (DataOut / DoutValid / ClkTx).
- Oversamples the slow transmit clock in the system clock domain and deserializes each 32-bit result frame.
- Splits each frame into operand A, operand B, ALU result, selector and flags.
- Buffers complete frames in a small first-word-fall-through FIFO for a host that pops them.

Parameters:
- FRAME_W, 32, frame length in bits.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 3, width of Level output; equals log2(DEPTH)+1.

Ports:
- Clk  in  1  system clock; frequency at least 4x ClkTx.
- Reset  in  1  asynchronous, active-low reset.
- ClkTx  in  1  transmit clock from upstream; asynchronous, sampled.
- DoutValid  in  1  upstream TxBusy; high for the whole frame.
- DataOut  in  1  serial data from upstream, MSB first.
- Pop  in  1  host consumes head entry.
- ClearErr  in  1  clears the sticky error flags.
- Frame  out  32  FIFO head, raw frame.
- OpA  out  8  Frame[31:24].
- OpB  out  8  Frame[23:16].
- AluOut  out  8  Frame[15:8].
- AluSel  out  4  Frame[7:4].
- AluFlags  out  4  Frame[3:0].
- Empty  out  1  FIFO empty.
- Full  out  1  FIFO full.
- Level  out  CNT_W  number of entries held.
- FrameErr  out  1  sticky: short or long frame seen.
- Overflow  out  1  sticky: complete frame dropped because the FIFO was full.

Behaviour:
- Reset (Reset=0, async) clears everything:
  - synchronizers, shift register, bit counter and FIFO pointers; FSM goes to IDLE.
  - Frame, OpA, OpB, AluOut, AluSel, AluFlags = 0.
  - Empty=1, Full=0, Level=0, FrameErr=0, Overflow=0.
- Input synchronization:
  - ClkTx, DoutValid and DataOut each pass through a 2-flop synchronizer.
  - A sample edge is the synchronized ClkTx going 0->1 (previous value held in a third flop).
  - DataOut is taken from the synchronizer stage aligned with ClkTx.
- FSM, states IDLE, RECV, DRAIN, COMMIT:
  - IDLE: bit count = 0. Synchronized DoutValid = 1 -> RECV.
  - RECV, sample edge with DoutValid=1 and count<32: shift reg = {shift[30:0], bit}, count++.
  - RECV, sample edge with DoutValid=1 and count==32: too-long frame. Set FrameErr -> DRAIN.
  - RECV, DoutValid falls with count==32 -> COMMIT.
  - RECV, DoutValid falls with count<32: short frame. Set FrameErr, discard shift reg -> IDLE.
  - DRAIN: ignore all edges until DoutValid=0 -> IDLE. Nothing is pushed.
  - COMMIT: exactly one cycle, then IDLE.
    - If not Full, or Pop is accepted in the same cycle: write the shift reg at the write pointer.
    - Otherwise drop the frame and set Overflow.
- Latency: Empty deasserts 1 Clk after the COMMIT cycle, i.e. at most 5 Clk after raw DoutValid falls.
- FIFO:
  - First-word-fall-through: Frame and the field outputs show the head entry combinationally; all zero when Empty.
  - Pop with Empty=0 advances the read pointer at the next edge.
  - Pop with Empty=1 is ignored; no error is raised.
  - Push and pop in the same cycle: Level unchanged, both pointers advance. This is allowed when Full.
  - Pointers wrap modulo DEPTH. Full/Empty come from an extra pointer MSB.
  - Level = write pointer - read pointer.
- Sticky flags:
  - FrameErr and Overflow hold until ClearErr=1 (one cycle clears both).
  - If ClearErr and a set event occur in the same cycle, the set wins.
- DoutValid re-asserting in the same cycle as COMMIT: the COMMIT completes; the new frame is detected from IDLE on the next cycle.
- Reset asserted mid-frame: partial frame lost, FIFO contents lost, no error flag.

Test Plan:
- Single frame: send 32'h1234_4600 MSB first, ClkTx = Clk/8 -> Empty=0 within 5 Clk of DoutValid fall. Check:
  - OpA=8'h12, OpB=8'h34, AluOut=8'h46, AluSel=4'h0, AluFlags=4'h0, Level=1.
  - Pop -> Empty=1, Frame=0.
- FIFO fill: send 4 frames 0xA5A5_0001..0xA5A5_0004 with no Pop -> Full=1, Level=4.
  - 5th frame 0xFFFF_FFFF -> Overflow=1, Frame still 0xA5A5_0001.
  - Pops return 0001..0004 in order.
- Error frames:
  - Short: DoutValid drops after 20 bits -> FrameErr=1, Level unchanged.
  - Long: 33 edges -> FrameErr=1, no push.
  - ClearErr pulse -> FrameErr=0.
- Simultaneous push/pop at Full: Pop asserted in the COMMIT cycle -> Level stays 4, Overflow=0, new frame appended.
- Reset mid-frame: assert Reset after 10 bits, release, send 32'h0000_00FF -> one entry, AluSel=4'hF, AluFlags=4'hF, FrameErr=0.
- Pop while empty: Pop held 3 cycles with Empty=1 -> Level=0, pointers unchanged. The next frame is read back correctly.
